// File: rtl/sensor_rx_pkg.sv
// Shared types for the sensor frame receiver: FSM states, header byte and record bundle.
package sensor_rx_pkg;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOIST,
        S_TEMP,
        S_LIGHT,
        S_CSUM
    } rx_state_t;

    typedef struct packed {
        logic [7:0] moisture;
        logic [7:0] temp;
        logic [7:0] light;
    } rec_t;

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchronizer followed by a registered rising-edge pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= i_async;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pulse <= r_s2 & ~r_s3;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/sensor_frame_rx.sv
// Byte-serial sensor frame receiver with checksum, timeout and one-entry holding register.
// Optional SENSOR_RX_AVG_EN: moisture output is a 4-record moving average.
module sensor_frame_rx
    import sensor_rx_pkg::*;
#(
    parameter logic [7:0] HEADER         = HDR_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic             stb_in,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [7:0]       moisture,
    output logic [7:0]       temp,
    output logic [7:0]       light,
    output logic [ERR_W-1:0] err_cnt,
    output logic             overflow
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    rx_state_t        r_state;
    rec_t             r_shadow;
    rec_t             r_hold;
    logic [TMO_W-1:0] r_tmo;
    logic             r_valid;
    logic [ERR_W-1:0] r_err;
    logic             r_ovf;

    logic       w_take;
    logic [7:0] w_csum;
    logic       w_in_csum;
    logic       w_csum_ok;
    logic       w_csum_bad;
    logic       w_tmo_exp;
    logic       w_load;
    logic       w_drop;
    logic [7:0] w_moist;

    sync_edge_det u_stb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (stb_in),
        .o_pulse (w_take)
    );

    assign w_csum     = r_shadow.moisture ^ r_shadow.temp ^ r_shadow.light;
    assign w_in_csum  = w_take && (r_state == S_CSUM);
    assign w_csum_ok  = w_in_csum && (byte_in == w_csum);
    assign w_csum_bad = w_in_csum && (byte_in != w_csum);
    assign w_tmo_exp  = !w_take && (r_state != S_IDLE) && (r_tmo == TMO_LAST);
    assign w_load     = w_csum_ok && (!r_valid || rec_ready);
    assign w_drop     = w_csum_ok && r_valid && !rec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_tmo    <= '0;
        end else if (w_take) begin
            r_tmo <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (byte_in == HEADER)
                        r_state <= S_MOIST;
                end
                S_MOIST: begin
                    r_shadow.moisture <= byte_in;
                    r_state           <= S_TEMP;
                end
                S_TEMP: begin
                    r_shadow.temp <= byte_in;
                    r_state       <= S_LIGHT;
                end
                S_LIGHT: begin
                    r_shadow.light <= byte_in;
                    r_state        <= S_CSUM;
                end
                S_CSUM:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end else if (r_state != S_IDLE) begin
            if (w_tmo_exp) begin
                r_state <= S_IDLE;
                r_tmo   <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

`ifdef SENSOR_RX_AVG_EN
    logic [7:0] r_hist [3];
    logic       r_hist_vld;
    logic [9:0] w_sum;

    always_comb begin
        w_sum = {r_shadow.moisture, 2'b00};
        if (r_hist_vld)
            w_sum = {2'b00, r_shadow.moisture} + {2'b00, r_hist[0]}
                  + {2'b00, r_hist[1]} + {2'b00, r_hist[2]};
        w_moist = w_sum[9:2];
    end

    // First loaded record seeds the whole window with its own value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist[0]  <= '0;
            r_hist[1]  <= '0;
            r_hist[2]  <= '0;
            r_hist_vld <= 1'b0;
        end else if (w_load) begin
            r_hist_vld <= 1'b1;
            r_hist[0]  <= r_shadow.moisture;
            r_hist[1]  <= r_hist_vld ? r_hist[0] : r_shadow.moisture;
            r_hist[2]  <= r_hist_vld ? r_hist[1] : r_shadow.moisture;
        end
    end
`else
    assign w_moist = r_shadow.moisture;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
            r_err   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_load) begin
                r_hold.moisture <= w_moist;
                r_hold.temp     <= r_shadow.temp;
                r_hold.light    <= r_shadow.light;
                r_valid         <= 1'b1;
            end else if (r_valid && rec_ready) begin
                r_valid <= 1'b0;
            end
            if (w_drop)
                r_ovf <= 1'b1;
            if ((w_csum_bad || w_tmo_exp) && (r_err != '1))
                r_err <= r_err + 1'b1;
        end
    end

    assign rec_valid = r_valid;
    assign moisture  = r_hold.moisture;
    assign temp      = r_hold.temp;
    assign light     = r_hold.light;
    assign err_cnt   = r_err;
    assign overflow  = r_ovf;

endmodule

// File: doc/sensor_frame_rx.md
Name: sensor_frame_rx

Overview:
- Upstream front-end of the precision-farming top (`tt_um_precision_farming`). Receives byte-serial sensor frames from the external microgreen sensor MCU on ui_in plus a strobe pin.
- Validates framing and checksum, then presents one moisture/temperature/light record to the decision core over a valid/ready handshake.
- Also keeps error statistics for debug readout on uio_out.

Parameters:
- HEADER, 8'hA5, start-of-frame byte.
- TIMEOUT_CYCLES, 1024, maximum clk cycles allowed between bytes inside a frame.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- byte_in  in  8  sensor data byte (ui_in).
- stb_in  in  1  asynchronous byte strobe from the MCU; a rising edge marks byte_in valid.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts the record.
- moisture  out  8  soil moisture, raw ADC count.
- temp  out  8  temperature, °C unsigned.
- light  out  8  light level.
- err_cnt  out  ERR_W  saturating count of checksum plus timeout errors.
- overflow  out  1  sticky: a valid frame was dropped because the holding register was full.

Behaviour:
- Reset: all outputs 0 and FSM in IDLE. Reset mid-frame discards the partial frame immediately; the synchronizer flops also clear.
- Strobe: stb_in passes a 2-FF synchronizer, then a rising-edge detect. The detect pulse ("take") occurs 3 clk after stb_in rises. byte_in must be stable from the stb_in rise through that cycle; it is sampled directly on take.
- FSM states: IDLE, MOIST, TEMP, LIGHT, CSUM.
  - IDLE: on take with byte==HEADER go to MOIST; any other byte is ignored (hunt mode).
  - MOIST, TEMP, LIGHT: on take, store the byte in a shadow register and advance.
  - CSUM: on take, compare the byte with moisture^temp^light from the shadows, then go to IDLE.
  - Inside a frame, a HEADER value is ordinary data; there is no mid-frame resync.
- Timeout: a counter clears on every take and runs while the FSM is not in IDLE. When it reaches TIMEOUT_CYCLES-1 without a take, go to IDLE and increment err_cnt. If a take arrives in the expiring cycle, the take wins and no error is counted.
- Checksum mismatch: increment err_cnt and drop the frame. err_cnt saturates at all-ones; it never wraps.
- Holding register (one entry):
  - On checksum match with rec_valid=0: copy the shadows into moisture/temp/light and set rec_valid the next cycle. Latency is 1 clk after the CSUM take.
  - On checksum match with rec_valid=1 and rec_ready=0: drop the new frame, set overflow, and leave outputs unchanged.
  - On checksum match in the same cycle as rec_valid&rec_ready: load the new record and keep rec_valid=1 (back-to-back).
- Handshake: transfer occurs when rec_valid&rec_ready. While rec_valid=1 the outputs are stable. rec_valid deasserts the cycle after the transfer unless reloaded as above.
- Clearing: overflow and err_cnt clear only on reset.

Optional Feature:
- Macro: SENSOR_RX_AVG_EN.
- Defined: the moisture output is the 4-sample moving average (sum>>2, 10-bit sum, truncating) of the last four loaded records.
  - The history window advances only when a record is loaded into the holding register; dropped frames do not enter it.
  - The first record after reset fills all four history slots with its own value.
  - temp and light are unaffected.
- Undefined: moisture is the raw byte; no history registers exist.

Decomposition:
- Package sensor_rx_pkg: FSM state enum (IDLE..CSUM), HEADER default, and the record struct {moisture, temp, light}.
- One sub-module, sync_edge_det: 2-FF synchronizer plus rising-edge pulse. It is reusable for other ui_in strobes.
- FSM, timeout, checksum and holding register stay in sensor_frame_rx.

Test Plan:
- Good frame A5 40 19 C8 91 with rec_ready=1 -> rec_valid pulses 1 cycle after the 5th take; moisture=0x40, temp=0x19, light=0xC8; err_cnt=0.
- Bad checksum A5 40 19 C8 90 -> rec_valid stays 0, err_cnt=1; a following good frame is still received.
- Send A5 40, then hold off stb_in for 1100 cycles -> FSM returns to IDLE at cycle 1023, err_cnt=1. A subsequent byte 19 is ignored (hunt mode).
- Two good frames with rec_ready=0 -> the first record is held unchanged and overflow=1. Raise rec_ready: the first record is transferred and rec_valid drops.
- Force 260 checksum errors -> err_cnt stops at 0xFF. Assert rst_n low mid-frame after A5 40 -> all outputs 0, then a clean frame is received normally.
- With SENSOR_RX_AVG_EN: moisture sequence 0x40, 0x80, 0x80, 0x80, 0x80 -> outputs 0x40, 0x50, 0x60, 0x70, 0x80.
